// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared slot geometry and FSM state encoding for the hazard controller.
package pipe_hazard_ctrl_pkg;
  localparam int NSLOT = 2;
  localparam int RAW = 5;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MC_WAIT = 2'd2} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// pipe_hazard_ctrl_lu_detect: flags any EX-stage load whose nonzero destination feeds an ID-stage source.
module pipe_hazard_ctrl_lu_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [NSLOT*RAW-1:0] id_rs,
  input  logic [NSLOT*RAW-1:0] id_rt,
  input  logic [NSLOT-1:0]     id_use_rt,
  input  logic [NSLOT-1:0]     ex_memread,
  input  logic [NSLOT*RAW-1:0] ex_rd,
  output logic                 lu_hit
);
  always_comb begin
    lu_hit = 1'b0;
    for (int e = 0; e < NSLOT; e++)
      for (int d = 0; d < NSLOT; d++)
        lu_hit = lu_hit | (ex_memread[e] && ex_rd[e*RAW+:RAW] != '0 &&
                 (ex_rd[e*RAW+:RAW] == id_rs[d*RAW+:RAW] ||
                  (id_use_rt[d] && ex_rd[e*RAW+:RAW] == id_rt[d*RAW+:RAW])));
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline-register enable/flush sequencing for load-use, taken-branch and multicycle-EX events.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int MC_MAX = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSLOT*RAW-1:0] id_rs,
  input  logic [NSLOT*RAW-1:0] id_rt,
  input  logic [NSLOT-1:0]     id_use_rt,
  input  logic [NSLOT-1:0]     ex_memread,
  input  logic [NSLOT*RAW-1:0] ex_rd,
  input  logic                 ex_br_taken,
  input  logic                 mc_start,
  input  logic                 mc_done,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 idex_write,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 mc_timeout,
  output logic [15:0]          stall_cnt
);
  localparam int CW = $clog2((FLUSH_DEPTH > MC_MAX ? FLUSH_DEPTH : MC_MAX) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic skip_mc, skip_n, to_n, lu_hit, mc_go, hold, br_run, lu_run;
  pipe_hazard_ctrl_lu_detect lu_detect (
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .lu_hit(lu_hit)
  );
  // State and counters move on the same negedge as the pipeline registers they steer.
  always_ff @(negedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      skip_mc <= 1'b0;
      mc_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      skip_mc <= skip_n;
      mc_timeout <= to_n;
    end
  end
  always_ff @(negedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (!pc_write && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    skip_n = skip_mc;
    to_n = mc_timeout;
    if (state == MC_WAIT) begin
      if (mc_done || cnt == CW'(MC_MAX)) begin
        state_n = RUN;
        skip_n = 1'b1;
        to_n = mc_timeout | !mc_done;
        cnt_n = '0;
      end else cnt_n = cnt + 1'b1;
    end else if (state == FLUSH) begin
      if (ex_br_taken) cnt_n = CW'(FLUSH_DEPTH - 1);
      else begin
        cnt_n = cnt - 1'b1;
        state_n = cnt == CW'(1) ? RUN : FLUSH;
      end
    end else begin
      state_n = RUN;
      skip_n = 1'b0;
      if (mc_go) begin
        state_n = MC_WAIT;
        cnt_n = CW'(1);
      end else if (ex_br_taken && FLUSH_DEPTH > 1) begin
        state_n = FLUSH;
        cnt_n = CW'(FLUSH_DEPTH - 1);
      end
    end
  end
  // skip_mc masks the held op's mc_start for the single RUN cycle after MC_WAIT exits.
  always_comb begin
    mc_go = mc_start && !skip_mc;
    hold = state == MC_WAIT || (state == RUN && mc_go);
    br_run = state == RUN && !mc_go && ex_br_taken;
    lu_run = state == RUN && !mc_go && !ex_br_taken && lu_hit;
    pc_write = !(hold || lu_run);
    ifid_write = !(hold || lu_run);
    idex_write = !hold;
    ifid_flush = state == FLUSH || br_run;
    idex_flush = br_run || lu_run;
    exmem_flush = hold;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queued scoreboard checked by an independent monitor.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [9:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic [1:0] id_use_rt = '0, ex_memread = '0;
  logic ex_br_taken = 1'b0, mc_start = 1'b0, mc_done = 1'b0;
  logic pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mc_timeout;
  logic [15:0] stall_cnt;
  int n_chk = 0, n_fail = 0;
  logic [22:0] exp_q[$];
  string name_q[$];
  // {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mc_timeout}
  localparam logic [6:0] D = 7'b1110000, LU = 7'b0010100, BR = 7'b1111100,
                         FL = 7'b1111000, MC = 7'b0000010, TO = 7'b0000001;
  pipe_hazard_ctrl #(.FLUSH_DEPTH(2), .MC_MAX(16)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .mc_start(mc_start), .mc_done(mc_done), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_write(idex_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .mc_timeout(mc_timeout), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  // Monitor samples on posedge, half a cycle clear of the negedge state update.
  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      logic [22:0] e, g;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      g = {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mc_timeout, stall_cnt};
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b stall=%0d, expected ctl=%b stall=%0d", nm, g[22:16], g[15:0], e[22:16], e[15:0]);
      end
    end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic cyc(input string nm, input logic [6:0] c, input int sc);
    exp_q.push_back({c, 16'(sc)});
    name_q.push_back(nm);
    tick();
  endtask
  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0; id_use_rt = '0; ex_memread = '0;
    ex_br_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    cyc("reset_state", D, 0);
    ex_memread = 2'b10; ex_rd = {5'd5, 5'd0}; id_rs = {5'd0, 5'd5}; id_rt = {5'd0, 5'd3}; id_use_rt = 2'b01;
    cyc("lu_stall", LU, 0);
    idle();
    cyc("lu_bubble_done", D, 1);
    ex_memread = 2'b01;
    cyc("load_r0", D, 1);
    ex_rd = {5'd0, 5'd9}; id_rt = {5'd9, 5'd0}; id_rs = {5'd1, 5'd2};
    cyc("rt_unused", D, 1);
    id_use_rt = 2'b10;
    cyc("rt_used", LU, 1);
    idle();
    cyc("rt_used_after", D, 2);
    ex_br_taken = 1'b1;
    cyc("br_cycle0", BR, 2);
    idle();
    ex_memread = 2'b10; ex_rd = {5'd5, 5'd0}; id_rs = {5'd0, 5'd5};
    cyc("br_cycle1_lu_ignored", FL, 2);
    idle();
    cyc("br_cycle2", D, 2);
    mc_start = 1'b1;
    cyc("mc_entry", MC, 2);
    for (int i = 0; i < 5; i++) begin
      mc_done = i == 4;
      cyc("mc_wait", MC, 3 + i);
    end
    mc_done = 1'b0;
    cyc("mc_skip", D, 8);
    mc_start = 1'b0;
    cyc("mc_after", D, 8);
    mc_start = 1'b1; ex_br_taken = 1'b1; mc_done = 1'b1;
    cyc("mcbr_entry_done_ignored", MC, 8);
    mc_done = 1'b0;
    cyc("mcbr_wait1", MC, 9);
    cyc("mcbr_wait2", MC, 10);
    mc_done = 1'b1;
    cyc("mcbr_wait3", MC, 11);
    mc_done = 1'b0;
    cyc("mcbr_skip_branch", BR, 12);
    idle();
    cyc("mcbr_flush", FL, 12);
    cyc("mcbr_run", D, 12);
    mc_start = 1'b1;
    cyc("to_entry", MC, 12);
    for (int i = 0; i < 16; i++) cyc("to_wait", MC, 13 + i);
    cyc("to_skip", D | TO, 29);
    cyc("to_reenter", MC | TO, 29);
    cyc("to_wait_again", MC | TO, 30);
    reset = 1'b1;
    mc_start = 1'b0;
    tick();
    reset = 1'b0;
    cyc("after_reset", D, 0);
    tick();
    tick();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
